sdram_burst_arbiter: RTL and testbench

- Single-port scheduler in front of the SDRAM controller, in the clk_ref (100 MHz) domain.
- Shares the SDRAM between two requesters: the flash loader's write FIFO, which fills one frame into SDRAM, and the LCD read FIFO, which streams that frame out continuously.
- Issues one burst command at a time to the controller and keeps the write and read frame pointers.
- Raises frame_write_done once the whole frame has been stored.

---
 rtl/sdram_burst_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_arbiter.sv
// Burst scheduler in front of the SDRAM controller. It shares one SDRAM port
// between the flash-loader write FIFO, which fills a frame, and the LCD read
// FIFO, which streams that frame out. Only one burst is outstanding at a time.
//
// state | meaning
// INIT  | waiting for the controller to finish initialisation
// ARB   | apply pending reload/vsync, otherwise pick the next burst
// REQ   | cmd_req high, command fields held until cmd_ack
// WAIT  | command accepted, waiting for burst_done
//
// Both requesters cannot be eligible together: writes need the frame to be
// unfinished and reads need it finished. The round-robin tie-break is kept so
// that the arbiter stays correct if that gating is ever relaxed.
module sdram_burst_arbiter #(
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 130560,
  parameter int FIFO_DEPTH  = 512,
  parameter int RD_LOW      = 128,
  parameter int ADDR_W      = 24
) (
  input  logic              clk_ref,
  input  logic              sys_rst,
  input  logic              sdram_init_done,
  input  logic [9:0]        wr_fifo_cnt,
  input  logic [9:0]        rd_fifo_cnt,
  input  logic              rd_frame_sync,
  input  logic              reload,
  output logic              cmd_req,
  input  logic              cmd_ack,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  input  logic              burst_done,
  output logic              frame_write_done,
  output logic              busy
);

  typedef enum logic [1:0] {S_INIT, S_ARB, S_REQ, S_WAIT} state_t;

  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
  localparam logic [8:0]        BURST_L   = 9'(BURST_LEN);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [8:0]        cmd_len_q, cmd_len_d;
  logic              cmd_req_q, cmd_req_d, cmd_wr_q, cmd_wr_d;
  logic              busy_q, busy_d, fwd_q, fwd_d;
  logic              last_wr_q, last_wr_d;
  logic              sync_pend_q, sync_pend_d, reload_pend_q, reload_pend_d;

  logic [ADDR_W-1:0] wr_rem, rd_rem, wr_next, rd_next;
  logic [8:0]        wr_len, rd_len;
  logic [10:0]       rd_need;
  logic              wr_ok, rd_ok, rd_urgent, grant_rd, grant_wr;

  // Remaining-length terms, eligibility and the grant decision.
  always_comb begin
    wr_rem    = FRAME_END - wr_ptr_q;
    rd_rem    = FRAME_END - rd_ptr_q;
    wr_len    = (wr_rem >= BURST_A) ? BURST_L : wr_rem[8:0];
    rd_len    = (rd_rem >= BURST_A) ? BURST_L : rd_rem[8:0];
    // Compare level + burst against depth so an over-range count cannot wrap.
    rd_need   = {1'b0, rd_fifo_cnt} + {2'b00, rd_len};
    wr_ok     = !fwd_q && (wr_fifo_cnt >= {1'b0, wr_len});
    rd_ok     = fwd_q && !sync_pend_q && (rd_need <= 11'(FIFO_DEPTH));
    rd_urgent = rd_ok && (rd_fifo_cnt < 10'(RD_LOW));
    grant_rd  = rd_urgent || (rd_ok && (!wr_ok || last_wr_q));
    grant_wr  = wr_ok && !grant_rd;
    wr_next   = wr_ptr_q + {{(ADDR_W-9){1'b0}}, cmd_len_q};
    rd_next   = rd_ptr_q + {{(ADDR_W-9){1'b0}}, cmd_len_q};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    cmd_req_d     = cmd_req_q;
    cmd_wr_d      = cmd_wr_q;
    busy_d        = busy_q;
    fwd_d         = fwd_q;
    last_wr_d     = last_wr_q;
    sync_pend_d   = sync_pend_q | rd_frame_sync;
    reload_pend_d = reload_pend_q | reload;
    case (state_q)
      S_INIT: begin
        if (sdram_init_done) state_d = S_ARB;
      end
      S_ARB: begin
        if (reload_pend_q) begin
          // A pulse arriving in this same cycle stays pending.
          reload_pend_d = reload;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          fwd_d         = 1'b0;
        end else if (sync_pend_q) begin
          sync_pend_d = rd_frame_sync;
          rd_ptr_d    = '0;
        end else if (grant_rd || grant_wr) begin
          cmd_wr_d   = grant_wr;
          cmd_addr_d = grant_wr ? wr_ptr_q : rd_ptr_q;
          cmd_len_d  = grant_wr ? wr_len : rd_len;
          cmd_req_d  = 1'b1;
          busy_d     = 1'b1;
          last_wr_d  = grant_wr;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (cmd_ack) begin
          cmd_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (burst_done) begin
          busy_d  = 1'b0;
          state_d = S_ARB;
          if (cmd_wr_q) begin
            wr_ptr_d = wr_next;
            if (wr_next == FRAME_END) fwd_d = 1'b1;
          end else begin
            rd_ptr_d = (rd_next == FRAME_END) ? '0 : rd_next;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      state_q       <= S_INIT;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      cmd_req_q     <= 1'b0;
      cmd_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      fwd_q         <= 1'b0;
      last_wr_q     <= 1'b0;
      sync_pend_q   <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      cmd_req_q     <= cmd_req_d;
      cmd_wr_q      <= cmd_wr_d;
      busy_q        <= busy_d;
      fwd_q         <= fwd_d;
      last_wr_q     <= last_wr_d;
      sync_pend_q   <= sync_pend_d;
      reload_pend_q <= reload_pend_d;
    end
  end

  assign cmd_req          = cmd_req_q;
  assign cmd_wr           = cmd_wr_q;
  assign cmd_addr         = cmd_addr_q;
  assign cmd_len          = cmd_len_q;
  assign busy             = busy_q;
  assign frame_write_done = fwd_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter with a 600-word frame, so the frame
// is three bursts of 256/256/88 words. A small controller model acks commands
// and returns burst_done; each scenario task checks its own expectations.
module tb_sdram_burst_arbiter;

  logic        clk_ref = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sdram_init_done = 1'b0;
  logic [9:0]  wr_fifo_cnt = '0;
  logic [9:0]  rd_fifo_cnt = '0;
  logic        rd_frame_sync = 1'b0;
  logic        reload = 1'b0;
  logic        cmd_req;
  logic        cmd_ack = 1'b0;
  logic        cmd_wr;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        burst_done = 1'b0;
  logic        frame_write_done;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  sdram_burst_arbiter #(
    .BURST_LEN(256), .FRAME_WORDS(600), .FIFO_DEPTH(512), .RD_LOW(128), .ADDR_W(24)
  ) dut (
    .clk_ref(clk_ref), .sys_rst(sys_rst), .sdram_init_done(sdram_init_done),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
    .rd_frame_sync(rd_frame_sync), .reload(reload),
    .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .burst_done(burst_done),
    .frame_write_done(frame_write_done), .busy(busy)
  );

  always #5 clk_ref = ~clk_ref;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Controller model. mode 1 pulses vsync while in WAIT, mode 2 pulses it
  // together with burst_done. Returns at the negedge after the done edge.
  task automatic serve(input int mode, output logic g_wr, output logic [23:0] g_addr,
                       output logic [8:0] g_len, output bit ok);
    ok = 1'b0;
    g_wr = 1'bx; g_addr = 'x; g_len = 'x;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_ref);
      if (cmd_req === 1'b1) ok = 1'b1;
    end
    if (!ok) return;
    g_wr = cmd_wr; g_addr = cmd_addr; g_len = cmd_len;
    cmd_ack = 1'b1;
    @(negedge clk_ref);
    cmd_ack = 1'b0;
    @(negedge clk_ref);
    if (mode == 1) begin
      rd_frame_sync = 1'b1;
      @(negedge clk_ref);
      rd_frame_sync = 1'b0;
      @(negedge clk_ref);
    end
    burst_done = 1'b1;
    if (mode == 2) rd_frame_sync = 1'b1;
    @(negedge clk_ref);
    burst_done = 1'b0;
    rd_frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_ref);
    chk_cnt++;
    if ({cmd_req, cmd_wr, cmd_addr, cmd_len, frame_write_done, busy} !== 37'd0)
      $display("FAIL reset_outputs: got req=%b wr=%b addr=%0d len=%0d fwd=%b busy=%b, expected all 0",
               cmd_req, cmd_wr, cmd_addr, cmd_len, frame_write_done, busy);
    else pass_cnt++;
    sys_rst = 1'b0;
    wr_fifo_cnt = 10'd300;
    rd_fifo_cnt = 10'd500;
    repeat (5) @(negedge clk_ref);
    chk_cnt++;
    if (cmd_req !== 1'b0) $display("FAIL init_hold: cmd_req=%b before init_done, expected 0", cmd_req);
    else pass_cnt++;
  endtask

  task automatic test_frame_load();
    logic [23:0] exp_addr [3] = '{24'd0, 24'd256, 24'd512};
    logic [8:0]  exp_len  [3] = '{9'd256, 9'd256, 9'd88};
    logic g_wr; logic [23:0] g_addr; logic [8:0] g_len; bit ok;
    sdram_init_done = 1'b1;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) begin
        chk_cnt++;
        if (frame_write_done !== 1'b0) $display("FAIL load_fwd_early: fwd=%b expected 0", frame_write_done);
        else pass_cnt++;
      end
      serve(0, g_wr, g_addr, g_len, ok);
      chk_cnt++;
      if (!ok) $display("FAIL load_timeout burst %0d: no cmd_req, expected one", b);
      else if ({g_wr, g_addr, g_len} !== {1'b1, exp_addr[b], exp_len[b]})
        $display("FAIL load_burst %0d: got wr=%b addr=%0d len=%0d expected wr=1 addr=%0d len=%0d",
                 b, g_wr, g_addr, g_len, exp_addr[b], exp_len[b]);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({frame_write_done, busy} !== 2'b10)
      $display("FAIL load_done: got fwd=%b busy=%b expected fwd=1 busy=0", frame_write_done, busy);
    else pass_cnt++;
    repeat (4) @(negedge clk_ref);
    chk_cnt++;
    if (cmd_req !== 1'b0) $display("FAIL idle_after_load: cmd_req=%b expected 0 (read FIFO full)", cmd_req);
    else pass_cnt++;
  endtask

  task automatic test_urgent_read_wrap();
    logic [23:0] exp_addr [4] = '{24'd0, 24'd256, 24'd512, 24'd0};
    logic [8:0]  exp_len  [4] = '{9'd256, 9'd256, 9'd88, 9'd256};
    logic g_wr; logic [23:0] g_addr; logic [8:0] g_len; bit ok;
    rd_fifo_cnt = 10'd0;
    wr_fifo_cnt = 10'd300;
    for (int b = 0; b < 4; b++) begin
      serve(0, g_wr, g_addr, g_len, ok);
      if (b == 3) rd_fifo_cnt = 10'd500;
      chk_cnt++;
      if (!ok) $display("FAIL read_timeout burst %0d: no cmd_req, expected one", b);
      else if ({g_wr, g_addr, g_len} !== {1'b0, exp_addr[b], exp_len[b]})
        $display("FAIL read_burst %0d: got wr=%b addr=%0d len=%0d expected wr=0 addr=%0d len=%0d",
                 b, g_wr, g_addr, g_len, exp_addr[b], exp_len[b]);
      else pass_cnt++;
    end
  endtask

  // Read pointer is 256 on entry; reads are non-urgent (level 200, space 312).
  task automatic test_frame_sync();
    logic [23:0] exp_addr [3] = '{24'd256, 24'd0, 24'd0};
    int          mode     [3] = '{1, 2, 0};
    logic g_wr; logic [23:0] g_addr; logic [8:0] g_len; bit ok;
    rd_fifo_cnt = 10'd200;
    for (int b = 0; b < 3; b++) begin
      serve(mode[b], g_wr, g_addr, g_len, ok);
      if (b == 2) rd_fifo_cnt = 10'd500;
      chk_cnt++;
      if (!ok) $display("FAIL sync_timeout burst %0d: no cmd_req, expected one", b);
      else if ({g_wr, g_addr, g_len} !== {1'b0, exp_addr[b], 9'd256})
        $display("FAIL sync_burst %0d: got wr=%b addr=%0d len=%0d expected wr=0 addr=%0d len=256",
                 b, g_wr, g_addr, g_len, exp_addr[b]);
      else pass_cnt++;
    end
  endtask

  // Read pointer is 256 on entry.
  task automatic test_ack_delay();
    bit ok = 1'b0;
    rd_fifo_cnt = 10'd200;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_ref);
      if (cmd_req === 1'b1) ok = 1'b1;
    end
    chk_cnt++;
    if (!ok) begin
      $display("FAIL ack_timeout: no cmd_req, expected one");
      return;
    end
    pass_cnt++;
    for (int c = 0; c < 7; c++) begin
      chk_cnt++;
      if ({cmd_req, cmd_wr, cmd_addr, cmd_len} !== {1'b1, 1'b0, 24'd256, 9'd256})
        $display("FAIL ack_hold cycle %0d: got req=%b wr=%b addr=%0d len=%0d expected req=1 wr=0 addr=256 len=256",
                 c, cmd_req, cmd_wr, cmd_addr, cmd_len);
      else pass_cnt++;
      if (c < 6) @(negedge clk_ref);
    end
    cmd_ack = 1'b1;
    @(negedge clk_ref);
    cmd_ack = 1'b0;
    chk_cnt++;
    if ({cmd_req, busy} !== 2'b01)
      $display("FAIL ack_release: got req=%b busy=%b expected req=0 busy=1", cmd_req, busy);
    else pass_cnt++;
    @(negedge clk_ref);
    burst_done = 1'b1;
    rd_fifo_cnt = 10'd500;
    @(negedge clk_ref);
    burst_done = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL ack_done_busy: busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  // Read pointer is 512 on entry, so the read is the 88-word tail.
  task automatic test_reset_in_wait();
    bit ok = 1'b0;
    rd_fifo_cnt = 10'd200;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_ref);
      if (cmd_req === 1'b1) ok = 1'b1;
    end
    chk_cnt++;
    if (!ok) $display("FAIL rst_timeout: no cmd_req, expected one");
    else if ({cmd_wr, cmd_addr, cmd_len} !== {1'b0, 24'd512, 9'd88})
      $display("FAIL rst_tail_read: got wr=%b addr=%0d len=%0d expected wr=0 addr=512 len=88",
               cmd_wr, cmd_addr, cmd_len);
    else pass_cnt++;
    cmd_ack = 1'b1;
    @(negedge clk_ref);
    cmd_ack = 1'b0;
    @(negedge clk_ref);
    sys_rst = 1'b1;
    rd_fifo_cnt = 10'd500;
    @(negedge clk_ref);
    chk_cnt++;
    if ({cmd_req, cmd_wr, cmd_addr, cmd_len, frame_write_done, busy} !== 37'd0)
      $display("FAIL rst_in_wait: got req=%b wr=%b addr=%0d len=%0d fwd=%b busy=%b expected all 0",
               cmd_req, cmd_wr, cmd_addr, cmd_len, frame_write_done, busy);
    else pass_cnt++;
    sys_rst = 1'b0;
  endtask

  task automatic test_reload();
    logic [23:0] exp_addr [3] = '{24'd0, 24'd256, 24'd512};
    logic [8:0]  exp_len  [3] = '{9'd256, 9'd256, 9'd88};
    logic g_wr; logic [23:0] g_addr; logic [8:0] g_len; bit ok;
    wr_fifo_cnt = 10'd300;
    for (int b = 0; b < 3; b++) begin
      serve(0, g_wr, g_addr, g_len, ok);
      chk_cnt++;
      if (!ok) $display("FAIL reload_load_timeout burst %0d: no cmd_req, expected one", b);
      else if ({g_wr, g_addr, g_len} !== {1'b1, exp_addr[b], exp_len[b]})
        $display("FAIL reload_load burst %0d: got wr=%b addr=%0d len=%0d expected wr=1 addr=%0d len=%0d",
                 b, g_wr, g_addr, g_len, exp_addr[b], exp_len[b]);
      else pass_cnt++;
    end
    wr_fifo_cnt = 10'd0;
    chk_cnt++;
    if (frame_write_done !== 1'b1) $display("FAIL reload_pre_fwd: fwd=%b expected 1", frame_write_done);
    else pass_cnt++;
    reload = 1'b1;
    @(negedge clk_ref);
    reload = 1'b0;
    repeat (2) @(negedge clk_ref);
    chk_cnt++;
    if (frame_write_done !== 1'b0) $display("FAIL reload_fwd_clear: fwd=%b expected 0", frame_write_done);
    else pass_cnt++;
    // 255 words is one short of a full first burst, so nothing may be issued.
    wr_fifo_cnt = 10'd255;
    repeat (5) @(negedge clk_ref);
    chk_cnt++;
    if (cmd_req !== 1'b0) $display("FAIL reload_short_fifo: cmd_req=%b expected 0", cmd_req);
    else pass_cnt++;
    wr_fifo_cnt = 10'd256;
    serve(0, g_wr, g_addr, g_len, ok);
    chk_cnt++;
    if (!ok) $display("FAIL reload_timeout: no cmd_req, expected one");
    else if ({g_wr, g_addr, g_len} !== {1'b1, 24'd0, 9'd256})
      $display("FAIL reload_first_write: got wr=%b addr=%0d len=%0d expected wr=1 addr=0 len=256",
               g_wr, g_addr, g_len);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame_load();
    test_urgent_read_wrap();
    test_frame_sync();
    test_ack_delay();
    test_reset_in_wait();
    test_reload();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
